// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CHK_W      = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
interface imem_loader_if #(
    parameter int AW = 10
) ();

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; word_valid is
// combinational on the byte that completes a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] acc;

    assign word_valid = byte_valid && (cnt == 2'(WORD_BYTES - 1));
    assign word       = {acc, byte_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (clr) begin
            cnt <= '0;
            acc <= '0;
        end else if (byte_valid) begin
            cnt <= cnt + 2'd1;
            acc <= {acc[15:0], byte_data};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream into instruction memory, CPU held
// in reset until a full image lands. Checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
//   state    | meaning
//   S_IDLE   | after reset, waiting for start
//   S_LEN_HI | expecting word-count high byte
//   S_LEN_LO | expecting word-count low byte
//   S_DATA   | receiving instruction bytes
//   S_CHK    | expecting XOR checksum byte
//   S_DONE   | image loaded, CPU released
//   S_ERR    | load aborted, CPU held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = S_CHK;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t        state, state_nxt;
    logic          in_ready;
    logic          accept;
    logic          clr;
    logic          word_valid;
    logic [31:0]   word;
    logic [7:0]    len_hi;
    logic [15:0]   len_word;
    logic [AW-1:0] addr_cnt;
    logic [AW-1:0] last_addr;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [31:0]   wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CHK_W-1:0] chk_acc;
`endif

    assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHK);
    assign accept   = bus.in_valid && in_ready;
    assign clr      = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign len_word = {len_hi, bus.in_data};

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);
    assign cpu_hold = (state != S_DONE);

    byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .byte_valid (accept && (state == S_DATA)),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_word > 16'(DEPTH)) state_nxt = S_ERR;
                    else if (len_word == 16'd0) state_nxt = END_STATE;
                    else                        state_nxt = S_DATA;
                end
            end
            S_DATA: if (word_valid && (addr_cnt == last_addr)) state_nxt = END_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: if (accept) state_nxt = (bus.in_data == chk_acc) ? S_DONE : S_ERR;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            addr_cnt  <= '0;
            last_addr <= '0;
            len_hi    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc   <= '0;
`endif
        end else begin
            wr_en_q <= word_valid;
            if (word_valid) begin
                wr_addr_q <= addr_cnt;
                wr_data_q <= word;
                // Hold on the last word so the counter never wraps at DEPTH.
                if (addr_cnt != last_addr) addr_cnt <= addr_cnt + 1'b1;
            end
            if (accept && (state == S_LEN_HI)) len_hi <= bus.in_data;
            if (accept && (state == S_LEN_LO)) last_addr <= AW'(len_word - 16'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept && (state == S_DATA)) chk_acc <= chk_acc ^ bus.in_data;
`endif
            if (clr) begin
                addr_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk_acc  <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory, the writer end of the fetch path. It accepts a byte stream on a valid/ready handshake, packs big-endian bytes into 32-bit instruction words, and writes them at consecutive word addresses from 0. It holds the processor in reset until a complete, well-formed image has been written.

## Interface
- `DEPTH`, 1024: instruction memory depth in words; maximum accepted word count.
- `AW`, 10: word-address width, `$clog2(DEPTH)`.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid` input 1: byte on `in_data` is valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader can accept a byte.
- `wr_en` output 1: one-cycle instruction-memory write strobe.
- `wr_addr` output AW: word address for the write.
- `wr_data` output 32: instruction word to write.
- `cpu_hold` output 1: high holds the processor (PC) in reset.
- `done` output 1: image loaded successfully.
- `error` output 1: load aborted.

## Operation
- Byte transfer occurs when `in_valid & in_ready` are both high at a rising edge. `in_valid` may drop at any time. Gaps never change the result.
- Stream format:
  - Count high byte, then count low byte (N words).
  - N × 4 data bytes, MSB first, for example 20 02 00 01 gives 0x20020001.
  - A checksum byte if configured (see Configuration).
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
  - IDLE to LEN_HI on `start`.
  - LEN_HI to LEN_LO on a byte.
  - LEN_LO, on a byte:
    - count > DEPTH goes to ERR;
    - count = 0 goes to CHK, or to DONE without the checksum feature;
    - otherwise goes to DATA.
  - DATA, on the 4th byte of word N-1: to CHK, or to DONE without the checksum feature.
  - CHK, on a byte: to DONE if it matches, else to ERR.
  - DONE and ERR go to LEN_HI on `start`. Entering LEN_HI clears `done` and `error` and sets `cpu_hold`.
- `in_ready` is 1 only in LEN_HI, LEN_LO, DATA and CHK.
- Words are written at addresses 0, 1, …, N-1. The address counter never wraps, because counts above DEPTH are rejected before any write.
- `start` pulses in LEN_HI, LEN_LO, DATA or CHK are ignored.
- Memory contents are not cleared by reset, restart or error. Words already written stay written.

## Timing
- Reset values:
  - `cpu_hold`=1;
  - `in_ready`=0, `wr_en`=0, `done`=0, `error`=0;
  - `wr_addr`=0, `wr_data`=0;
  - state IDLE.
- A `reset_n` assertion mid-load returns the block to these values immediately. A partially assembled word is discarded.
- `wr_en`, `wr_addr` and `wr_data` are registered. The strobe is high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
- `done`, `error` and `cpu_hold` update one cycle after the terminating byte is accepted.
  - `cpu_hold` falls when `done` rises.
  - `cpu_hold` stays 1 in ERR.
- Maximum throughput is one byte per cycle.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - a trailing byte equal to the XOR of all N×4 data bytes is required;
  - for N=0 the expected byte is 0x00;
  - a mismatch sets `error` and keeps `cpu_hold` high.
- `IMEM_LOADER_CHECKSUM_EN` undefined: no CHK state. The image ends after the last data byte.

## Structure
- Package `imem_loader_pkg` contains:
  - the state enum;
  - `LEN_BYTES`=2 and `WORD_BYTES`=4;
  - the checksum width.
- Sub-module `byte_packer`:
  - shifts in bytes MSB-first with a 2-bit byte counter;
  - emits `word_valid` and the 32-bit word on the 4th byte;
  - clears on `clr`.

## Test plan
- Reset: `reset_n`=0, then held → `cpu_hold`=1, `in_ready`=0, `wr_en`=0, `done`=0, `error`=0.
- Good load with checksum:
  - stimulus: `start`, then 00 02 20 02 00 01 20 03 00 02 02;
  - required writes: addr 0 = 0x20020001, addr 1 = 0x20030002, one `wr_en` cycle each;
  - then `done`=1 and `cpu_hold`=0.
- Same image with random `in_valid` gaps → identical writes and timing relative to each accepted byte.
- Count 0x0401 with DEPTH=1024 → `error`=1 after the low count byte, no writes, `in_ready`=0, `cpu_hold`=1.
- Good image with checksum byte 0x03 → both words written, then `error`=1 and `cpu_hold` stays 1. A later `start` plus a correct image → `done`=1.
- `reset_n` pulsed low after 2 data bytes → all outputs return to reset values with no write. A new `start` and full image → correct writes from addr 0.
